// File: rtl/prim_rr_idx_arb.sv
// Round-robin arbiter returning the winner as a binary index; zero latency from req_i while unlocked.
// Under backpressure the choice is locked until ready_i; fairness pointer advances only on handshake.
module prim_rr_idx_arb #(
  parameter  int N    = 8,
  localparam int IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o,
  output logic            hs_o,
  output logic            err_o
);

  logic [IdxW-1:0] ptr_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            err_q;

  logic            hi_found, lo_found;
  logic [IdxW-1:0] hi_idx, lo_idx;
  logic [IdxW-1:0] rr_idx;

  // Two priority scans: first request at or above the pointer, and first overall for the wrap case.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (req_i[k] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IdxW'(k);
      end
      if (req_i[k] && (k >= int'(ptr_q)) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = IdxW'(k);
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  assign valid_o = lock_q | (|req_i);
  assign idx_o   = lock_q ? lock_idx_q : rr_idx;
  assign hs_o    = valid_o & ready_i;
  assign err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= lock_q & ~req_i[lock_idx_q];
      if (hs_o) begin
        ptr_q <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
      end
      if (!lock_q && valid_o && !ready_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= idx_o;
      end else if (lock_q && ready_i) begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prim_rr_idx_arb.sv
// Directed bench for prim_rr_idx_arb: an N=8 instance for most scenarios and an N=5 instance for wrap.
module tb_prim_rr_idx_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic       ready8;
  logic       valid8, hs8, err8;
  logic [2:0] idx8;
  logic [4:0] req5;
  logic       ready5;
  logic       valid5, hs5, err5;
  logic [2:0] idx5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prim_rr_idx_arb #(.N(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req8), .ready_i(ready8),
    .valid_o(valid8), .idx_o(idx8), .hs_o(hs8), .err_o(err8)
  );

  prim_rr_idx_arb #(.N(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req5), .ready_i(ready5),
    .valid_o(valid5), .idx_o(idx5), .hs_o(hs5), .err_o(err5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1ns after the edge and sampled 1ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req8 = '0; ready8 = 1'b0; req5 = '0; ready5 = 1'b0;
    #2;
    check("rst_valid", valid8, 0);
    check("rst_idx", idx8, 0);
    check("rst_err", err8, 0);
    check("rst_hs", hs8, 0);
    req8 = 8'h24;
    #1;
    check("rst_comb_valid", valid8, 1);
    check("rst_comb_idx", idx8, 2);
    req8 = '0;
    tick; tick;
    rst_n = 1'b1;

    // Fairness sweep with everyone requesting.
    for (int i = 0; i < 10; i++) begin
      req8 = 8'hFF; ready8 = 1'b1;
      #1;
      check("sweep_idx", idx8, i % 8);
      check("sweep_hs", hs8, 1);
      tick;
    end

    // ptr is 2; grant 2 to move it to 3.
    req8 = 8'h04; ready8 = 1'b1;
    #1; check("ptr3_prep", idx8, 2);
    tick;
    req8 = 8'b0010_0100;
    #1; check("ptr3_idx5", idx8, 5);
    check("ptr3_hs", hs8, 1);
    tick;
    #1; check("wrap_idx2", idx8, 2);
    // Grant 7 so the pointer returns to 0.
    req8 = 8'h80;
    #1; check("to_ptr0", idx8, 7);
    tick;

    // Backpressure lock on 2, higher-priority bit 0 arrives while locked.
    req8 = 8'h0C; ready8 = 1'b0;
    #1; check("bp_c1_idx", idx8, 2);
    check("bp_c1_valid", valid8, 1);
    check("bp_c1_hs", hs8, 0);
    tick;
    req8 = 8'h0D;
    #1; check("bp_c2_idx", idx8, 2);
    check("bp_c2_valid", valid8, 1);
    tick;
    #1; check("bp_c3_idx", idx8, 2);
    check("bp_c3_err", err8, 0);
    tick;
    ready8 = 1'b1;
    #1; check("bp_c4_hs", hs8, 1);
    check("bp_c4_idx", idx8, 2);
    tick;
    #1; check("bp_next_idx", idx8, 3);
    tick;

    // ptr is 4: lock on 2 then drop its request for one cycle.
    req8 = 8'h04; ready8 = 1'b0;
    #1; check("viol_lock_idx", idx8, 2);
    tick;
    req8 = 8'h00;
    #1; check("viol_drop_valid", valid8, 1);
    check("viol_drop_idx", idx8, 2);
    check("viol_drop_err", err8, 0);
    tick;
    req8 = 8'h04;
    #1; check("viol_err_pulse", err8, 1);
    check("viol_err_idx", idx8, 2);
    tick;
    #1; check("viol_err_clear", err8, 0);
    ready8 = 1'b1;
    #1; check("viol_release_hs", hs8, 1);
    check("viol_release_idx", idx8, 2);
    tick;
    req8 = '0; ready8 = 1'b0;

    // Non-power-of-two wrap on the N=5 instance.
    for (int i = 0; i < 6; i++) begin
      req5 = 5'h1F; ready5 = 1'b1;
      #1;
      check("n5_idx", idx5, i % 5);
      check("n5_hs", hs5, 1);
      tick;
    end
    req5 = '0; ready5 = 1'b0;

    // ptr is 3: lock on 6, raise err, then reset mid-lock.
    req8 = 8'h40; ready8 = 1'b0;
    #1; check("rl_idx6", idx8, 6);
    tick;
    req8 = 8'h00;
    tick;
    #1; check("rl_err_set", err8, 1);
    check("rl_locked_idx", idx8, 6);
    req8 = 8'h30;
    rst_n = 1'b0;
    #1; check("rl_rst_valid", valid8, 1);
    check("rl_rst_idx", idx8, 4);
    check("rl_rst_err", err8, 0);
    req8 = 8'h00;
    #1; check("rl_rst_novalid", valid8, 0);
    tick;
    rst_n = 1'b1;
    req8 = 8'hFF; ready8 = 1'b1;
    #1; check("rl_restart_idx", idx8, 0);
    tick;
    #1; check("rl_restart_next", idx8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prim_rr_idx_arb.md
Name: prim_rr_idx_arb

Overview:
- Round-robin arbiter over N requesters; returns the winner as a binary index with a valid/ready handshake.
- Sits directly upstream of prim_onehot_enc: idx_o drives in_i and (valid_o & ready_i) drives en_i, which yields a one-hot grant vector.
- Holds its choice stable under backpressure and advances fairness state only on an accepted grant.

Parameters:
- N, 8, number of requesters; legal range 2..256, need not be a power of two.
- IdxW, $clog2(N), derived localparam, index width; not overridable.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous and active-low.
- req_i  input  N  request vector; bit k = requester k wants service.
- ready_i  input  1  downstream accepts the current index this cycle.
- valid_o  output  1  idx_o holds a valid winner.
- idx_o  output  IdxW  winning requester index.
- hs_o  output  1  handshake this cycle (valid_o & ready_i); intended as en_i of prim_onehot_enc.
- err_o  output  1  registered one-cycle pulse: a locked requester dropped its request.

Behaviour:
- One clock: clk_i. Reset: rst_ni, asynchronous assert, active-low. All flops reset asynchronously.
- State registers:
  - ptr_q (IdxW bits, reset 0): highest-priority index.
  - lock_q (1 bit, reset 0).
  - lock_idx_q (IdxW bits, reset 0).
  - err_q (1 bit, reset 0).
- Reset output values:
  - err_o=0.
  - valid_o = |req_i and idx_o follow the combinational UNLOCKED rule (lock_q=0).
  - With req_i=0: valid_o=0, idx_o=0.
- UNLOCKED (lock_q=0):
  - Combinational, zero latency from req_i to valid_o/idx_o.
  - Winner = lowest k >= ptr_q with req_i[k]=1. If none exists, winner = lowest k overall with req_i[k]=1.
  - valid_o = |req_i.
  - idx_o = winner, or 0 if no request.
  - Request bits at index >= N do not exist. ptr_q is always < N.
- LOCKED (lock_q=1):
  - valid_o=1 and idx_o=lock_idx_q regardless of req_i.
  - New requests, including ones of higher priority, are ignored until handshake.
- Transitions, evaluated at each clock edge:
  - UNLOCKED & valid_o & ~ready_i -> LOCKED; lock_idx_q <= idx_o.
  - LOCKED & ready_i -> UNLOCKED.
  - UNLOCKED & valid_o & ready_i -> stays UNLOCKED (single-cycle grant).
  - Any other case: state unchanged.
- Pointer update: on every handshake, ptr_q <= (idx_o == N-1) ? 0 : idx_o+1. Wrap is at N, not 2^IdxW. There is no pointer change without a handshake.
- err: err_q <= lock_q & ~req_i[lock_idx_q]; err_o = err_q.
  - Indicates a protocol violation. The block keeps presenting the locked index; no other effect.
- Simultaneous events:
  - The handshake and a new request in the same cycle are both honoured. The next-cycle winner uses the updated ptr_q.
  - A handshake in the lock-entry cycle is impossible: lock only forms when ready_i=0.
- Reset mid-lock: lock_q, ptr_q and err_q clear immediately (asynchronous). After release, arbitration restarts from index 0.
- Fairness: with all N requesting continuously and ready_i=1, grants cycle 0,1,...,N-1,0. Any requester waits at most N-1 handshakes.

Test Plan:
- Reset, then N=8, req_i=8'hFF, ready_i=1 for 10 cycles -> idx_o sequence 0,1,2,3,4,5,6,7,0,1; hs_o=1 every cycle.
- req_i=8'b0010_0100 with ptr_q=3 -> idx_o=5. After handshake ptr_q=6, so the next winner is 2 (wrap search).
- Backpressure: req_i=8'h0C, ready_i=0 for 3 cycles, then at cycle 2 raise req_i bit 0 -> idx_o stays 2 and valid_o=1 throughout. ready_i=1 on cycle 4 -> hs_o=1 with idx_o=2, then the next winner is 3.
- Protocol violation: lock on idx 2, deassert req_i[2] -> err_o=1 exactly one cycle later; idx_o still 2 until ready_i=1.
- N=5 (non-power-of-two), all requesting -> sequence 0,1,2,3,4,0; ptr_q never reaches 5..7.
- Assert rst_ni=0 while locked on idx 6 -> valid_o follows req_i immediately and err_o=0. After release with req_i=8'hFF -> idx_o=0.
